// File: rtl/sa_pkg.sv
// Shared types and defaults for the placement server: op and FSM encodings,
// default table geometry and a saturating counter helper.
package sa_pkg;

  localparam int unsigned DefNCells   = 16;
  localparam int unsigned DefCellBits = 4;
  localparam int unsigned DefNNodes   = 12;

  typedef enum logic {
    OpRead = 1'b0,
    OpSwap = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLookup  = 2'd1,
    StSwap    = 2'd2,
    StRespond = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sa_placement_server_if.sv
// Request/response channel between an initiator and the placement server.
interface sa_placement_server_if
  import sa_pkg::*;
#(
  parameter int unsigned CELL_BITS = DefCellBits
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_op;
  logic [CELL_BITS-1:0] req_ca;
  logic [CELL_BITS-1:0] req_cb;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [CELL_BITS-1:0] rsp_na;
  logic [CELL_BITS-1:0] rsp_nb;
  logic                 rsp_na_v;
  logic                 rsp_nb_v;

  modport master (
    output req_valid, req_op, req_ca, req_cb, rsp_ready,
    input  req_ready, rsp_valid, rsp_na, rsp_nb, rsp_na_v, rsp_nb_v
  );

  modport slave (
    input  req_valid, req_op, req_ca, req_cb, rsp_ready,
    output req_ready, rsp_valid, rsp_na, rsp_nb, rsp_na_v, rsp_nb_v
  );

endinterface

// File: rtl/sa_placement_table.sv
// Cell-to-node and node-to-cell placement tables. Two async c2n read ports,
// two c2n write ports and two n2c write ports; reset loads the identity map.
module sa_placement_table
  import sa_pkg::*;
#(
  parameter int unsigned N_CELLS   = DefNCells,
  parameter int unsigned CELL_BITS = DefCellBits,
  parameter int unsigned N_NODES   = DefNNodes
) (
  input  logic                 clk,
  input  logic                 rst,
  // c2n read ports
  input  logic [CELL_BITS-1:0] rd_a_cell,
  output logic                 rd_a_valid,
  output logic [CELL_BITS-1:0] rd_a_node,
  input  logic [CELL_BITS-1:0] rd_b_cell,
  output logic                 rd_b_valid,
  output logic [CELL_BITS-1:0] rd_b_node,
  // c2n write ports
  input  logic                 c2n_we_a,
  input  logic [CELL_BITS-1:0] c2n_cell_a,
  input  logic                 c2n_valid_a,
  input  logic [CELL_BITS-1:0] c2n_node_a,
  input  logic                 c2n_we_b,
  input  logic [CELL_BITS-1:0] c2n_cell_b,
  input  logic                 c2n_valid_b,
  input  logic [CELL_BITS-1:0] c2n_node_b,
  // n2c write ports
  input  logic                 n2c_we_a,
  input  logic [CELL_BITS-1:0] n2c_node_a,
  input  logic [CELL_BITS-1:0] n2c_cell_a,
  input  logic                 n2c_we_b,
  input  logic [CELL_BITS-1:0] n2c_node_b,
  input  logic [CELL_BITS-1:0] n2c_cell_b
);

  logic                 c2n_valid_q [N_CELLS];
  logic [CELL_BITS-1:0] c2n_node_q  [N_CELLS];
  logic [CELL_BITS-1:0] n2c_q       [N_NODES];

  // Asynchronous lookups of both addressed cells.
  always_comb begin
    rd_a_valid = c2n_valid_q[rd_a_cell];
    rd_a_node  = c2n_node_q[rd_a_cell];
    rd_b_valid = c2n_valid_q[rd_b_cell];
    rd_b_node  = c2n_node_q[rd_b_cell];
  end

  // Table state: identity on reset, otherwise apply the enabled writes.
  // When both ports hit the same entry they carry the same value (ca==cb swap).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CELLS; i++) begin
        c2n_valid_q[i] <= (i < N_NODES);
        c2n_node_q[i]  <= (i < N_NODES) ? CELL_BITS'(i) : '0;
      end
      for (int unsigned j = 0; j < N_NODES; j++) begin
        n2c_q[j] <= CELL_BITS'(j);
      end
    end else begin
      for (int unsigned i = 0; i < N_CELLS; i++) begin
        if (c2n_we_a && (c2n_cell_a == CELL_BITS'(i))) begin
          c2n_valid_q[i] <= c2n_valid_a;
          c2n_node_q[i]  <= c2n_node_a;
        end
        if (c2n_we_b && (c2n_cell_b == CELL_BITS'(i))) begin
          c2n_valid_q[i] <= c2n_valid_b;
          c2n_node_q[i]  <= c2n_node_b;
        end
      end
      for (int unsigned j = 0; j < N_NODES; j++) begin
        if (n2c_we_a && (n2c_node_a == CELL_BITS'(j))) n2c_q[j] <= n2c_cell_a;
        if (n2c_we_b && (n2c_node_b == CELL_BITS'(j))) n2c_q[j] <= n2c_cell_b;
      end
    end
  end

  // Mapping invariant: the cell each node points at must hold that node.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned j = 0; j < N_NODES; j++) begin
        assert (c2n_valid_q[n2c_q[j]] && (c2n_node_q[n2c_q[j]] == CELL_BITS'(j)));
      end
    end
  end

endmodule

// File: rtl/sa_placement_server.sv
// Placement server: serves one READ or SWAP request at a time against the
// placement tables and returns the nodes found at both cells before the swap.
module sa_placement_server
  import sa_pkg::*;
#(
  parameter int unsigned N_CELLS   = DefNCells,
  parameter int unsigned CELL_BITS = DefCellBits,
  parameter int unsigned N_NODES   = DefNNodes
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  sa_placement_server_if.slave  bus,
  output logic [15:0]           swap_count
);

  state_e               state_q;
  op_e                  op_q;
  logic [CELL_BITS-1:0] ca_q, cb_q;
  logic                 na_v_q, nb_v_q;
  logic [CELL_BITS-1:0] na_q, nb_q;
  logic                 rsp_valid_q;
  logic                 rsp_na_v_q, rsp_nb_v_q;
  logic [CELL_BITS-1:0] rsp_na_q, rsp_nb_q;

  logic                 rd_a_valid, rd_b_valid;
  logic [CELL_BITS-1:0] rd_a_node, rd_b_node;
  logic                 swap_en;

  // Handshake and response outputs.
  always_comb begin
    bus.req_ready = (state_q == StIdle) && start;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_na    = rsp_na_q;
    bus.rsp_nb    = rsp_nb_q;
    bus.rsp_na_v  = rsp_na_v_q;
    bus.rsp_nb_v  = rsp_nb_v_q;
    swap_en       = (state_q == StSwap);
  end

  sa_placement_table #(
    .N_CELLS   (N_CELLS),
    .CELL_BITS (CELL_BITS),
    .N_NODES   (N_NODES)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .rd_a_cell   (ca_q),
    .rd_a_valid  (rd_a_valid),
    .rd_a_node   (rd_a_node),
    .rd_b_cell   (cb_q),
    .rd_b_valid  (rd_b_valid),
    .rd_b_node   (rd_b_node),
    .c2n_we_a    (swap_en),
    .c2n_cell_a  (ca_q),
    .c2n_valid_a (nb_v_q),
    .c2n_node_a  (nb_q),
    .c2n_we_b    (swap_en),
    .c2n_cell_b  (cb_q),
    .c2n_valid_b (na_v_q),
    .c2n_node_b  (na_q),
    .n2c_we_a    (swap_en && na_v_q),
    .n2c_node_a  (na_q),
    .n2c_cell_a  (cb_q),
    .n2c_we_b    (swap_en && nb_v_q),
    .n2c_node_b  (nb_q),
    .n2c_cell_b  (ca_q)
  );

  // Request FSM with registered response outputs. rsp_valid rises one cycle
  // after entering RESPOND so the response fields are loaded alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpRead;
      ca_q        <= '0;
      cb_q        <= '0;
      na_v_q      <= 1'b0;
      nb_v_q      <= 1'b0;
      na_q        <= '0;
      nb_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_na_v_q  <= 1'b0;
      rsp_nb_v_q  <= 1'b0;
      rsp_na_q    <= '0;
      rsp_nb_q    <= '0;
      swap_count  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid && bus.req_ready) begin
            op_q    <= op_e'(bus.req_op);
            ca_q    <= bus.req_ca;
            cb_q    <= bus.req_cb;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          na_v_q  <= rd_a_valid;
          na_q    <= rd_a_node;
          nb_v_q  <= rd_b_valid;
          nb_q    <= rd_b_node;
          state_q <= (op_q == OpSwap) ? StSwap : StRespond;
        end
        StSwap: begin
          swap_count <= sat_inc16(swap_count);
          state_q    <= StRespond;
        end
        StRespond: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_na_v_q  <= na_v_q;
            rsp_nb_v_q  <= nb_v_q;
            rsp_na_q    <= na_q;
            rsp_nb_q    <= nb_q;
          end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
